// File: rtl/board_io_gpio_bridge.sv
// ---------------------------------------------------------------------------
// board_io_gpio_bridge
//
// Purpose:
//   Glue between the Zynq PS 64-bit EMIO GPIO bus and the board's buttons,
//   switches and LEDs. Every raw button/switch pin is brought into the clk
//   domain with a two-flop synchroniser and then debounced. Rising edges of
//   debounced buttons latch sticky "pressed" flags that software clears by
//   pulsing a strobe bit. Each LED runs in one of four software-selected
//   modes: off, level, blink or PWM.
//
// Ports:
//   clk       in   1             system clock (FCLK_CLK0)
//   reset     in   1             synchronous, active-high reset
//   buttons   in   NUM_BUTTONS   raw asynchronous button pins
//   switches  in   NUM_SWITCHES  raw asynchronous switch pins
//   leds      out  NUM_LEDS      LED pins, registered
//   gpio_o    in   64            PS GPIO output bus (control from software)
//   gpio_i    out  64            PS GPIO input bus (status to software), registered
//
// Control word (gpio_o):
//   [7:0]              LED level bits, bit i drives LED i in level mode
//   [16+2i+1:16+2i]    mode of LED i (00 off, 01 level, 10 blink, 11 pwm)
//   [47:40]            PWM duty, low PWM_BITS bits used
//   [48]               sticky-flag clear strobe, acts on its rising edge
//
// Status word (gpio_i):
//   [NB-1:0]           debounced buttons
//   [NB+NS-1:NB]       debounced switches
//   [2NB+NS-1:NB+NS]   sticky press flags
//   everything else    0
// ---------------------------------------------------------------------------
module board_io_gpio_bridge #(
    parameter int NUM_BUTTONS     = 4,
    parameter int NUM_SWITCHES    = 2,
    parameter int NUM_LEDS        = 4,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int BLINK_CYCLES    = 25000000,
    parameter int PWM_BITS        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_BUTTONS-1:0]  buttons,
    input  logic [NUM_SWITCHES-1:0] switches,
    output logic [NUM_LEDS-1:0]     leds,
    input  logic [63:0]             gpio_o,
    output logic [63:0]             gpio_i
);

    localparam int NUM_INPUTS = NUM_BUTTONS + NUM_SWITCHES;
    localparam int DB_W       = $clog2(DEBOUNCE_CYCLES);
    localparam int BLINK_W    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    localparam int CLR_BIT   = 48;
    localparam int DUTY_LSB  = 40;
    localparam int MODE_LSB  = 16;

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_LEVEL = 2'b01,
        LED_BLINK = 2'b10,
        LED_PWM   = 2'b11
    } ledMode_t;

    // Input path: buttons occupy the low bits so the status word can take
    // the debounced vector as-is.
    logic [NUM_INPUTS-1:0]  w_rawIn;
    logic [NUM_INPUTS-1:0]  r_sync1;
    logic [NUM_INPUTS-1:0]  r_sync2;
    logic [NUM_INPUTS-1:0]  r_stable;
    logic [NUM_INPUTS-1:0]  w_commit;
    logic [DB_W-1:0]        r_dbCnt [NUM_INPUTS];

    // Sticky flags and the clear-strobe edge detector.
    logic [NUM_BUTTONS-1:0] w_pressRise;
    logic [NUM_BUTTONS-1:0] r_flags;
    logic                   r_clrDly;
    logic                   w_clrPulse;

    // Shared LED timebases.
    logic [BLINK_W-1:0]     r_blinkCnt;
    logic                   r_blinkPhase;
    logic [PWM_BITS-1:0]    r_pwmCnt;
    logic [PWM_BITS-1:0]    w_duty;

    // Next values of the registered outputs.
    logic [NUM_LEDS-1:0]    w_ledNext;
    logic [63:0]            w_status;

    // Most control bits are reserved; folding the whole bus into one bit
    // keeps the reserved bits visibly accounted for.
    logic                   w_unusedGpio;

    assign w_rawIn      = {switches, buttons};
    assign w_unusedGpio = ^gpio_o;

    // Two-flop synchroniser for every raw pin. The pins are fully
    // asynchronous to clk, so nothing downstream may look at w_rawIn.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_rawIn;
            r_sync2 <= r_sync1;
        end
    end

    // An input commits to its new value on the cycle its counter has seen
    // DEBOUNCE_CYCLES consecutive disagreeing samples. Exposed as a vector
    // because the flag logic needs to know about button commits in the same
    // cycle the stable value changes.
    always_comb begin
        w_commit = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_commit[i] = (r_sync2[i] != r_stable[i]) && (r_dbCnt[i] == DB_LAST);
        end
    end

    // Per-input debouncer. Any sample that agrees with the stable value
    // restarts the count, so a glitch shorter than DEBOUNCE_CYCLES can
    // never change the stable value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (w_commit[i]) begin
                    r_stable[i] <= r_sync2[i];
                    r_dbCnt[i]  <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A press is a debounced 0->1 commit of a button. Detecting it at commit
    // time, rather than from the registered stable value, lets the flag land
    // in gpio_i in the same cycle as the debounced button bit.
    assign w_pressRise = w_commit[NUM_BUTTONS-1:0] & r_sync2[NUM_BUTTONS-1:0];

    // Software clears flags on the rising edge of the strobe only, so
    // leaving the strobe high does not keep wiping new presses.
    assign w_clrPulse = gpio_o[CLR_BIT] & ~r_clrDly;

    // Sticky press flags. The set term is OR-ed in after the clear so that
    // a press arriving together with a clear is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clrDly <= 1'b0;
            r_flags  <= '0;
        end else begin
            r_clrDly <= gpio_o[CLR_BIT];
            r_flags  <= w_pressRise | (r_flags & ~{NUM_BUTTONS{w_clrPulse}});
        end
    end

    // Shared blink timebase: the phase flips each time the counter wraps,
    // giving a square wave with a half-period of BLINK_CYCLES.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else if (r_blinkCnt == BLINK_LAST) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= ~r_blinkPhase;
        end else begin
            r_blinkCnt <= r_blinkCnt + BLINK_W'(1);
        end
    end

    // Shared PWM ramp, free-running through its natural binary wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwmCnt <= '0;
        end else begin
            r_pwmCnt <= r_pwmCnt + PWM_BITS'(1);
        end
    end

    assign w_duty = gpio_o[DUTY_LSB +: PWM_BITS];

    // LED mode decode. Mode and duty are used straight from the control
    // bus; a change simply applies from the next clock, with no attempt to
    // wait for the end of a PWM period. A strict less-than compare makes
    // duty 0 fully dark and duty max dark for exactly one ramp step.
    always_comb begin
        w_ledNext = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (ledMode_t'(gpio_o[MODE_LSB + 2*i +: 2]))
                LED_OFF:   w_ledNext[i] = 1'b0;
                LED_LEVEL: w_ledNext[i] = gpio_o[i];
                LED_BLINK: w_ledNext[i] = r_blinkPhase;
                LED_PWM:   w_ledNext[i] = (r_pwmCnt < w_duty);
                default:   w_ledNext[i] = 1'b0;
            endcase
        end
    end

    // Assemble the status word; unused bits read back as zero.
    always_comb begin
        w_status                             = '0;
        w_status[NUM_INPUTS-1:0]             = r_stable;
        w_status[NUM_INPUTS +: NUM_BUTTONS]  = r_flags;
    end

    // Output registers, so both the pins and the PS see glitch-free values.
    always_ff @(posedge clk) begin
        if (reset) begin
            leds   <= '0;
            gpio_i <= '0;
        end else begin
            leds   <= w_ledNext;
            gpio_i <= w_status;
        end
    end

endmodule
